jt12_ch_acc: RTL and testbench
==============================

JT12_CH_ACC -- requirements
Module: jt12_ch_acc

Interface
REQ-001 SHALL have parameter num_ch, default 6; number of time-multiplexed channels per operator group (only 6 supported).
REQ-002 SHALL have ports in this order:
- rst  input  1  synchronous reset, active-high
- clk  input  1  system clock
- clk_en  input  1  cycle enable; all state advances only when high
- zero  input  1  marks the current input as slot 0 of a 24-slot frame
- op_result  input  14  signed linear operator output, one slot per clk_en cycle
- carrier  input  1  current slot's operator is a carrier for its channel's algorithm
- ch_out  output  14  signed saturated channel sum
- ch_idx  output  3  channel number of ch_out (0..5)
- ch_valid  output  1  one-clk_en-cycle strobe: ch_out/ch_idx updated
- ovf  output  1  sticky flag: saturation occurred since reset or last clear
- ovf_clr  input  1  clears ovf
REQ-003 The block SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 Slot counter slot (0..23) SHALL load 0 when zero=1 and clk_en=1, else increment modulo 24 per clk_en cycle; the loaded or incremented value is the slot of the current input.
REQ-005 Slot mapping: channel = slot mod 6; group = slot div 6; group 0..3 = operators S1,S3,S2,S4.
REQ-006 Accumulators SHALL be a 6-stage, 16-bit signed shift ring, one entry per channel, advancing once per clk_en cycle.
REQ-007 Group 0: entry SHALL load carrier ? sext(op_result) : 0 (fresh start, no add).
REQ-008 Groups 1,2: entry SHALL load entry + (carrier ? sext(op_result) : 0), full 16-bit, no wrap possible.
REQ-009 Group 3: final = entry + (carrier ? sext(op_result) : 0); ch_out SHALL be final saturated to [-8192, +8191]; ch_idx = channel; ch_valid=1 on the next clk_en cycle after the S4 input; latency 1 clk_en cycle.
REQ-010 ch_out/ch_idx SHALL hold between strobes; ch_valid SHALL be 0 in all other cycles, including clk_en=0 cycles.
REQ-011 Saturation event SHALL set ovf; ovf_clr=1 SHALL clear ovf; simultaneous set and clear: set wins.
REQ-012 zero mid-frame SHALL resync the counter immediately; partial sums are discarded by REQ-007; output is correct from the first full frame after resync; a strobe for group 3 of a truncated frame is still emitted.
REQ-013 clk_en=0 SHALL freeze counter, ring, outputs and ovf (ovf_clr ignored).

Reset
REQ-014 rst=1 SHALL act on any clk edge regardless of clk_en: slot=0, ring entries=0, ch_out=0, ch_idx=0, ch_valid=0, ovf=0.
REQ-015 rst mid-frame SHALL abort all sums; first input after reset is slot 0 unless zero says otherwise.

Structure
REQ-016 Frame constants (24 slots, 6 channels, group order, saturation limits 14'sh1FFF/14'sh2000) SHALL live in the shared jt12 package.
REQ-017 The accumulator ring SHALL reuse jt12_sh_rst (width 16, stages 6); no other sub-module.

Verification
REQ-018 Frame with all carriers, op_result=100 every slot -> ch_valid on slots 18..23 (+1), ch_out=400, ch_idx 0..5.
REQ-019 Only S4 carrier, op_result=-8192 on ch2, 0 elsewhere -> ch_out=-8192 for ch2, ovf stays 0.
REQ-020 All carriers, ch1 op_result=8191 in all four groups -> ch_out=8191, ovf=1; next ovf_clr -> ovf=0.
REQ-021 zero pulsed at slot 10 -> counter reloads 0; first full frame after sums correct; no stale partial sums.
REQ-022 clk_en toggling 1-of-3 with all carriers, op_result=5 -> identical results to continuous clk_en (ch_out=20), ch_valid only on enabled cycles.
REQ-023 rst asserted at slot 14 with clk_en=0 -> all outputs 0 on next edge; the following frame's sums are correct.

Source files
------------

// File: rtl/jt12_pkg.sv
// Shared frame constants and slot-decoding helpers for the jt12 operator pipeline.
// A frame holds 24 slots: four operator groups (S1,S3,S2,S4), each spanning the six channels.
package jt12_pkg;

  localparam int unsigned SLOTS    = 24;
  localparam int unsigned CHANNELS = 6;
  localparam logic [4:0]  LAST_SLOT = 5'(SLOTS - 1);

  localparam logic signed [13:0] SAT_MAX = 14'sh1FFF;
  localparam logic signed [13:0] SAT_MIN = 14'sh2000;

  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } grp_e;

  typedef struct packed {
    logic signed [13:0] val;
    logic               hit;
  } sat_t;

  function automatic grp_e slot_grp(input logic [4:0] slot);
    grp_e g;
    if (slot < 5'(CHANNELS))          g = GRP_S1;
    else if (slot < 5'(2 * CHANNELS)) g = GRP_S3;
    else if (slot < 5'(3 * CHANNELS)) g = GRP_S2;
    else                              g = GRP_S4;
    return g;
  endfunction

  function automatic logic [2:0] slot_ch(input logic [4:0] slot);
    logic [4:0] base;
    base = 5'(slot_grp(slot)) * 5'(CHANNELS);
    return 3'(slot - base);
  endfunction

  // Clamp a 16-bit channel sum to the 14-bit output range and flag clipping.
  function automatic sat_t sat14(input logic signed [15:0] v);
    sat_t r;
    logic signed [15:0] hi;
    logic signed [15:0] lo;
    hi = {{2{SAT_MAX[13]}}, SAT_MAX};
    lo = {{2{SAT_MIN[13]}}, SAT_MIN};
    if (v > hi)      r = '{val: SAT_MAX, hit: 1'b1};
    else if (v < lo) r = '{val: SAT_MIN, hit: 1'b1};
    else             r = '{val: v[13:0], hit: 1'b0};
    return r;
  endfunction

endpackage

// File: rtl/jt12_sh_rst.sv
// Clock-enabled shift ring with synchronous reset; drop_o is the value pushed 'stages' enables ago.
module jt12_sh_rst #(
  parameter int width  = 16,
  parameter int stages = 6
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             clk_en,
  input  logic [width-1:0] din_i,
  output logic [width-1:0] drop_o
);

  logic [width-1:0] bits_q [stages];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < stages; i++) bits_q[i] <= '0;
    end else if (clk_en) begin
      bits_q[0] <= din_i;
      for (int i = 1; i < stages; i++) bits_q[i] <= bits_q[i-1];
    end
  end

  assign drop_o = bits_q[stages-1];

endmodule

// File: rtl/jt12_ch_acc.sv
// Per-channel accumulator: sums carrier operator outputs over a 24-slot frame and
// emits one saturated 14-bit sample per channel as group S4 completes.
module jt12_ch_acc
  import jt12_pkg::*;
#(
  parameter int num_ch = 6
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               clk_en,
  input  logic               zero,
  input  logic signed [13:0] op_result,
  input  logic               carrier,
  output logic signed [13:0] ch_out,
  output logic [2:0]         ch_idx,
  output logic               ch_valid,
  output logic               ovf,
  input  logic               ovf_clr
);

  // slot_q holds the slot number the next input will take (0 straight after reset)
  logic [4:0]         slot_q, slot_d, cur_slot;
  grp_e               grp;
  logic [2:0]         ch;
  logic signed [15:0] opx, entry, acc, ring_din;
  sat_t               sat;
  logic signed [13:0] ch_out_q;
  logic [2:0]         ch_idx_q;
  logic               strobe_q;
  logic               ovf_q, ovf_d;

  always_comb begin
    cur_slot = zero ? 5'd0 : slot_q;
    slot_d   = (cur_slot == LAST_SLOT) ? 5'd0 : cur_slot + 5'd1;
    grp      = slot_grp(cur_slot);
    ch       = slot_ch(cur_slot);
    opx      = carrier ? {{2{op_result[13]}}, op_result} : 16'sd0;
    acc      = entry + opx;
    ring_din = (grp == GRP_S1) ? opx : acc;
    sat      = sat14(acc);
    ovf_d    = ovf_q;
    if ((grp == GRP_S4) && sat.hit) ovf_d = 1'b1;
    else if (ovf_clr)               ovf_d = 1'b0;
  end

  jt12_sh_rst #(
    .width  (16),
    .stages (num_ch)
  ) u_ring (
    .rst    (rst),
    .clk    (clk),
    .clk_en (clk_en),
    .din_i  (ring_din),
    .drop_o (entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= 5'd0;
      ch_out_q <= '0;
      ch_idx_q <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clk_en) begin
      slot_q   <= slot_d;
      strobe_q <= (grp == GRP_S4);
      ovf_q    <= ovf_d;
      if (grp == GRP_S4) begin
        ch_out_q <= sat.val;
        ch_idx_q <= ch;
      end
    end
  end

  // The strobe is held across disabled cycles but only shown on an enabled one.
  assign ch_valid = strobe_q & clk_en;
  assign ch_out   = ch_out_q;
  assign ch_idx   = ch_idx_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_jt12_ch_acc.sv
// Self-checking bench for jt12_ch_acc: directed frames plus randomized traffic
// compared against a per-channel integer sum model.
module tb_jt12_ch_acc;

  logic               rst, clk, clk_en, zero, carrier, ovf_clr;
  logic signed [13:0] op_result;
  logic signed [13:0] ch_out;
  logic [2:0]         ch_idx;
  logic               ch_valid, ovf;

  int compared   = 0;
  int mismatched = 0;

  int sums [6];
  int nextSlot;
  int modelOut, modelIdx;
  bit modelStrobe, modelOvf;

  jt12_ch_acc #(.num_ch(6)) dut (
    .rst       (rst),
    .clk       (clk),
    .clk_en    (clk_en),
    .zero      (zero),
    .op_result (op_result),
    .carrier   (carrier),
    .ch_out    (ch_out),
    .ch_idx    (ch_idx),
    .ch_valid  (ch_valid),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Frame model: slots numbered from zero/wrap, each channel summed over its four groups.
  task automatic modelStep(input bit r, input bit en, input bit z, input int op,
                           input bit car, input bit clr);
    int slot, ch, grp, v, s;
    if (r) begin
      nextSlot = 0; modelOut = 0; modelIdx = 0; modelStrobe = 0; modelOvf = 0;
      for (int i = 0; i < 6; i++) sums[i] = 0;
    end else if (en) begin
      slot = z ? 0 : nextSlot;
      ch   = slot % 6;
      grp  = slot / 6;
      v    = car ? op : 0;
      if (grp == 0) sums[ch] = v;
      else          sums[ch] = sums[ch] + v;
      s = sums[ch];
      modelStrobe = (grp == 3);
      if (grp == 3) begin
        if (s > 8191)  s = 8191;
        if (s < -8192) s = -8192;
        modelOut = s;
        modelIdx = ch;
      end
      if (grp == 3 && s != sums[ch]) modelOvf = 1;
      else if (clr)                  modelOvf = 0;
      nextSlot = (slot + 1) % 24;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit en, input bit z, input int op,
                               input bit car, input bit clr);
    @(negedge clk);
    rst = r; clk_en = en; zero = z; op_result = 14'(op); carrier = car; ovf_clr = clr;
    #1;
    checkOutput("valid", int'(ch_valid), int'(modelStrobe && en));
    checkOutput("out", int'(ch_out), modelOut);
    checkOutput("idx", int'(ch_idx), modelIdx);
    checkOutput("ovf", int'(ovf), int'(modelOvf));
    @(posedge clk);
    modelStep(r, en, z, op, car, clr);
  endtask

  initial begin
    bit r, en, z, car, clr;
    int op;

    rst = 1'b1; clk_en = 1'b0; zero = 1'b0; op_result = '0; carrier = 1'b0; ovf_clr = 1'b0;
    modelStep(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstOut", int'(ch_out), 0);
    checkOutput("rstIdx", int'(ch_idx), 0);
    checkOutput("rstValid", int'(ch_valid), 0);
    checkOutput("rstOvf", int'(ovf), 0);

    // All carriers at 100: every channel sums to 400
    for (int s = 0; s < 24; s++) applyStimulus(0, 1, s == 0, 100, 1, 0);
    #1;
    checkOutput("r18Out", int'(ch_out), 400);
    checkOutput("r18Idx", int'(ch_idx), 5);
    checkOutput("r18Valid", int'(ch_valid), 1);

    // Only S4 is a carrier; ch2 hits the negative limit exactly
    for (int s = 0; s < 24; s++) begin
      applyStimulus(0, 1, s == 0, (s == 20) ? -8192 : 0, s >= 18, 0);
      if (s == 20) begin
        #1;
        checkOutput("r19Out", int'(ch_out), -8192);
        checkOutput("r19Idx", int'(ch_idx), 2);
        checkOutput("r19Ovf", int'(ovf), 0);
      end
    end

    // ch1 at 8191 in every group saturates; clear on the following slot
    for (int s = 0; s < 24; s++) begin
      applyStimulus(0, 1, s == 0, (s % 6 == 1) ? 8191 : 0, 1, s == 20);
      if (s == 19) begin
        #1;
        checkOutput("r20Out", int'(ch_out), 8191);
        checkOutput("r20Ovf", int'(ovf), 1);
      end
      if (s == 20) begin
        #1;
        checkOutput("r20Clr", int'(ovf), 0);
      end
    end

    // clk_en one cycle in three
    for (int i = 0; i < 72; i++) applyStimulus(0, i % 3 == 0, i == 0, 5, 1, 0);
    #1;
    checkOutput("r22Out", int'(ch_out), 20);
    checkOutput("r22Idx", int'(ch_idx), 5);
    checkOutput("r22Valid", int'(ch_valid), 0);

    // Resync at slot 10, stale partial sums must vanish
    for (int s = 0; s < 10; s++) applyStimulus(0, 1, s == 0, 1000, 1, 0);
    for (int s = 0; s < 24; s++) applyStimulus(0, 1, s == 0, 7, 1, 0);
    #1;
    checkOutput("r21Out", int'(ch_out), 28);
    checkOutput("r21Idx", int'(ch_idx), 5);

    // Reset mid-frame while disabled, then a frame with no zero marker
    for (int s = 0; s < 14; s++) applyStimulus(0, 1, s == 0, 50, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("r23Out", int'(ch_out), 0);
    checkOutput("r23Idx", int'(ch_idx), 0);
    checkOutput("r23Valid", int'(ch_valid), 0);
    checkOutput("r23Ovf", int'(ovf), 0);
    for (int s = 0; s < 24; s++) applyStimulus(0, 1, 0, 100, 1, 0);
    #1;
    checkOutput("r23Sum", int'(ch_out), 400);

    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 3) != 0);
      z   = ($urandom_range(0, 59) == 0);
      op  = int'($urandom_range(0, 16383)) - 8192;
      car = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 15) == 0);
      applyStimulus(r, en, z, op, car, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
